// File: rtl/mtc_sl_serializer.sv
//------------------------------------------------------------------------------
// mtc_sl_serializer
//
// Takes MTC_PER_BCID candidate words per clock, keeps the ones whose MSB
// (valid bit) is set, and packs them in ascending lane order into a
// show-ahead FIFO. The FIFO drains one word per cycle onto the sector-logic
// link using a ready/valid handshake. Valid lanes that do not fit are
// dropped, counted in a saturating counter, and flagged by a sticky bit.
//
// Ports:
//   clock       in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   srst        in   synchronous active-high soft reset (same effect as rst_n)
//   mtc_in      in   MTC_PER_BCID candidate words, MSB = valid
//   out_data    out  FIFO head word (0 when out_valid is low)
//   out_valid   out  FIFO not empty
//   out_ready   in   link accepts out_data this cycle
//   fifo_count  out  FIFO occupancy
//   drop_cnt    out  dropped candidates, saturating at 16'hFFFF
//   overflow    out  sticky, set on the first drop
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mtc_sl_serializer #(
    parameter int unsigned MTC_WIDTH    = 32,
    parameter int unsigned MTC_PER_BCID = 3,
    parameter int unsigned FIFO_DEPTH   = 8,
    localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 srst,
    input  logic [MTC_WIDTH-1:0] mtc_in [MTC_PER_BCID],
    output logic [MTC_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        fifo_count,
    output logic [15:0]          drop_cnt,
    output logic                 overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [MTC_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [MTC_WIDTH-1:0] mem_d [FIFO_DEPTH];

    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [15:0]          drop_q, drop_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic [MTC_WIDTH-1:0] data_q, data_d;

    logic                 pop_c;
    int unsigned          nwr_c;
    int unsigned          free_c;
    int unsigned          acc_c;
    int unsigned          ndrop_c;
    int unsigned          rank_c;
    int unsigned          dsum_c;

    always_comb begin
        pop_c = valid_q & out_ready;

        nwr_c = 0;
        for (int unsigned i = 0; i < MTC_PER_BCID; i++) begin
            if (mtc_in[i][MTC_WIDTH-1]) nwr_c = nwr_c + 1;
        end

        // A pop this cycle frees its slot for a same-cycle write.
        free_c  = FIFO_DEPTH + 32'(pop_c) - 32'(count_q);
        acc_c   = (nwr_c < free_c) ? nwr_c : free_c;
        ndrop_c = nwr_c - acc_c;

        // Compaction: the n-th valid lane goes to wr_ptr+n; only the
        // lowest-ranked acc_c valid lanes are written.
        mem_d  = mem_q;
        rank_c = 0;
        for (int unsigned i = 0; i < MTC_PER_BCID; i++) begin
            if (mtc_in[i][MTC_WIDTH-1]) begin
                if (rank_c < acc_c) begin
                    mem_d[AW'(32'(wr_ptr_q) + rank_c)] = mtc_in[i];
                end
                rank_c = rank_c + 1;
            end
        end

        wr_ptr_d = AW'(32'(wr_ptr_q) + acc_c);
        rd_ptr_d = AW'(32'(rd_ptr_q) + 32'(pop_c));
        count_d  = CW'(32'(count_q) + acc_c - 32'(pop_c));

        dsum_c = 32'(drop_q) + ndrop_c;
        drop_d = (dsum_c > 32'h0000_FFFF) ? 16'hFFFF : 16'(dsum_c);
        ovf_d  = ovf_q | (ndrop_c != 0);

        // The head register is loaded from the post-write memory image so a
        // word written into an empty FIFO is visible the very next cycle.
        valid_d = (count_d != '0);
        data_d  = valid_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else if (srst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    // Storage needs no reset: pointers and count define which slots are live.
    always_ff @(posedge clock) begin
        if (rst_n && !srst) begin
            mem_q <= mem_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign fifo_count = count_q;
    assign drop_cnt   = drop_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mtc_sl_serializer.sv
//------------------------------------------------------------------------------
// tb_mtc_sl_serializer
//
// Self-checking bench for mtc_sl_serializer (32-bit words, 3 lanes, depth 8).
// Directed vectors come from a table; random traffic is compared against a
// queue-based reference model of the FIFO and drop policy.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mtc_sl_serializer;

    localparam int W     = 32;
    localparam int LANES = 3;
    localparam int DEPTH = 8;

    logic          clock;
    logic          rst_n;
    logic          srst;
    logic [W-1:0]  mtc_in [LANES];
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    fifo_count;
    logic [15:0]   drop_cnt;
    logic          overflow;

    mtc_sl_serializer #(
        .MTC_WIDTH    (W),
        .MTC_PER_BCID (LANES),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .srst       (srst),
        .mtc_in     (mtc_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [W-1:0] m_q[$];
    int           m_drop;
    bit           m_ovf;

    typedef struct {
        logic [W-1:0] l0;
        logic [W-1:0] l1;
        logic [W-1:0] l2;
        logic         rdy;
        int           cnt;
        int           drp;
        logic         ovf;
        logic [W-1:0] data;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [W-1:0] V(input int n);
        return 32'h8000_0000 | 32'(n);
    endfunction

    function automatic vec_t mk(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                input logic [W-1:0] l2, input logic rdy,
                                input int cnt, input int drp, input logic ovf,
                                input logic [W-1:0] data);
        vec_t v;
        v.l0 = l0; v.l1 = l1; v.l2 = l2; v.rdy = rdy;
        v.cnt = cnt; v.drp = drp; v.ovf = ovf; v.data = data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    // Cycle rule: pop the head if the link takes it, then append valid lanes
    // in lane order while the queue has room; the rest are dropped.
    task automatic model_edge(input logic [W-1:0] l0, input logic [W-1:0] l1,
                              input logic [W-1:0] l2, input logic rdy);
        logic [W-1:0] ln [LANES];
        ln[0] = l0; ln[1] = l1; ln[2] = l2;
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        for (int i = 0; i < LANES; i++) begin
            if (ln[i][W-1]) begin
                if (m_q.size() < DEPTH) m_q.push_back(ln[i]);
                else begin
                    if (m_drop < 65535) m_drop++;
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [W-1:0] exp_data;
        exp_data = (m_q.size() != 0) ? m_q[0] : '0;
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_q.size() != 0));
        chk({tag, ".data"},  out_data, exp_data);
        chk({tag, ".count"}, 32'(fifo_count), 32'(m_q.size()));
        chk({tag, ".drop"},  32'(drop_cnt), 32'(m_drop));
        chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    endtask

    // Drive one cycle: inputs change #1 after the previous edge, outputs are
    // sampled #1 after this edge.
    task automatic step(input logic [W-1:0] l0, input logic [W-1:0] l1,
                        input logic [W-1:0] l2, input logic rdy,
                        input bit do_chk, input string tag);
        mtc_in[0] = l0; mtc_in[1] = l1; mtc_in[2] = l2;
        out_ready = rdy;
        @(posedge clock);
        if (srst) model_reset();
        else      model_edge(l0, l1, l2, rdy);
        #1;
        if (do_chk) check_model(tag);
    endtask

    function automatic logic [W-1:0] rnd_lane();
        logic [W-1:0] w;
        w = $urandom;
        w[W-1] = ($urandom_range(0, 99) < 60);
        return w;
    endfunction

    initial begin
        logic [W-1:0] inv;
        int           p;
        inv = 32'h7FFF_FFFF;

        // Reset held with all lanes valid: nothing captured, all outputs 0.
        rst_n = 1'b0; srst = 1'b0; out_ready = 1'b1;
        mtc_in[0] = V(1); mtc_in[1] = V(2); mtc_in[2] = V(3);
        model_reset();
        repeat (3) begin
            @(posedge clock); #1;
            chk("rst.valid", 32'(out_valid), 32'd0);
            chk("rst.data",  out_data, 32'd0);
            chk("rst.count", 32'(fifo_count), 32'd0);
            chk("rst.drop",  32'(drop_cnt), 32'd0);
            chk("rst.ovf",   32'(overflow), 32'd0);
        end
        mtc_in[0] = '0; mtc_in[1] = '0; mtc_in[2] = '0;
        rst_n = 1'b1;

        // {A,B,C} after reset
        tbl.push_back(mk(V('hA), V('hB), V('hC), 1'b1, 3, 0, 1'b0, V('hA)));
        tbl.push_back(mk('0, '0, '0, 1'b1, 2, 0, 1'b0, V('hB)));
        tbl.push_back(mk('0, '0, '0, 1'b1, 1, 0, 1'b0, V('hC)));
        tbl.push_back(mk('0, '0, '0, 1'b1, 0, 0, 1'b0, '0));
        // sparse lanes: lane 0 invalid with nonzero payload
        tbl.push_back(mk(inv, V('h55), V('h66), 1'b1, 2, 0, 1'b0, V('h55)));
        tbl.push_back(mk('0, '0, '0, 1'b1, 1, 0, 1'b0, V('h66)));
        tbl.push_back(mk('0, '0, '0, 1'b1, 0, 0, 1'b0, '0));
        // overflow with out_ready low
        tbl.push_back(mk(V(1), V(2), V(3), 1'b0, 3, 0, 1'b0, V(1)));
        tbl.push_back(mk(V(4), V(5), V(6), 1'b0, 6, 0, 1'b0, V(1)));
        tbl.push_back(mk(V(7), V(8), V(9), 1'b0, 8, 1, 1'b1, V(1)));
        // full with simultaneous pop: one accepted, two dropped
        tbl.push_back(mk(V(10), V(11), V(12), 1'b1, 8, 3, 1'b1, V(2)));
        // drain
        tbl.push_back(mk('0, '0, '0, 1'b1, 7, 3, 1'b1, V(3)));
        tbl.push_back(mk('0, '0, '0, 1'b1, 6, 3, 1'b1, V(4)));
        tbl.push_back(mk('0, '0, '0, 1'b1, 5, 3, 1'b1, V(5)));
        tbl.push_back(mk('0, '0, '0, 1'b1, 4, 3, 1'b1, V(6)));
        tbl.push_back(mk('0, '0, '0, 1'b1, 3, 3, 1'b1, V(7)));
        tbl.push_back(mk('0, '0, '0, 1'b1, 2, 3, 1'b1, V(8)));
        tbl.push_back(mk('0, '0, '0, 1'b1, 1, 3, 1'b1, V(10)));
        tbl.push_back(mk('0, '0, '0, 1'b1, 0, 3, 1'b1, '0));

        foreach (tbl[k]) begin
            step(tbl[k].l0, tbl[k].l1, tbl[k].l2, tbl[k].rdy, 1'b1, "vec");
            chk($sformatf("tbl%0d.count", k), 32'(fifo_count), 32'(tbl[k].cnt));
            chk($sformatf("tbl%0d.valid", k), 32'(out_valid), 32'(tbl[k].cnt != 0));
            chk($sformatf("tbl%0d.data", k),  out_data, tbl[k].data);
            chk($sformatf("tbl%0d.drop", k),  32'(drop_cnt), 32'(tbl[k].drp));
            chk($sformatf("tbl%0d.ovf", k),   32'(overflow), 32'(tbl[k].ovf));
        end

        // Mid-operation srst with 5 words held and drop/overflow nonzero.
        step(V(21), V(22), V(23), 1'b0, 1'b1, "pre_srst");
        step(V(24), V(25), '0,    1'b0, 1'b1, "pre_srst");
        chk("pre_srst.count5", 32'(fifo_count), 32'd5);
        srst = 1'b1;
        step(V(26), V(27), V(28), 1'b1, 1'b1, "srst");
        srst = 1'b0;
        chk("srst.count", 32'(fifo_count), 32'd0);
        chk("srst.valid", 32'(out_valid), 32'd0);
        chk("srst.drop",  32'(drop_cnt), 32'd0);
        chk("srst.ovf",   32'(overflow), 32'd0);
        step('0, '0, '0, 1'b1, 1'b1, "post_srst");

        // Random traffic with phases of varying link back-pressure.
        for (int c = 0; c < 10000; c++) begin
            p = (c < 3000) ? 50 : (c < 6000) ? 90 : 25;
            step(rnd_lane(), rnd_lane(), rnd_lane(),
                 ($urandom_range(0, 99) < p), 1'b1, "rand");
        end

        // Drop counter saturation: link stalled, all lanes valid.
        for (int c = 0; c < 21900; c++) begin
            step(V(c), V(c + 1), V(c + 2), 1'b0, 1'b0, "sat");
        end
        check_model("sat");
        chk("sat.drop_max", 32'(drop_cnt), 32'h0000_FFFF);
        for (int c = 0; c < 10; c++) begin
            step('0, '0, '0, 1'b1, 1'b1, "sat_drain");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mtc_sl_serializer.md
# mtc_sl_serializer

Downstream stage of the MTC builder. Each clock it takes the `MTC_PER_BCID` registered MTC candidate words, keeps only those with the valid bit set, and packs them in order into a show-ahead FIFO. It then drains the FIFO one word per cycle onto the sector-logic link interface using a ready/valid handshake. Overflow is handled by a defined drop policy with a saturating drop counter.

## Interface
Parameters:
- `MTC_WIDTH`, default `MTC2SL_LEN`: candidate word width. Bit `MTC_WIDTH-1` is the valid bit.
- `MTC_PER_BCID`, default 3: number of input lanes.
- `FIFO_DEPTH`, default 8: must be a power of two and ≥ `MTC_PER_BCID`.
- `CW = $clog2(FIFO_DEPTH)+1`: count width (derived localparam).

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `srst`  in  1  synchronous soft reset, active-high; same effect as `rst_n`.
- `mtc_in[MTC_PER_BCID]`  in  `MTC_WIDTH` each  candidates from the MTC builder.
- `out_data`  out  `MTC_WIDTH`  FIFO head word, sent to the SL link.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  SL link accepts the word this cycle.
- `fifo_count`  out  `CW`  current FIFO occupancy.
- `drop_cnt`  out  16  number of dropped candidates; saturates at 16'hFFFF.
- `overflow`  out  1  sticky; set on the first drop.

## Operation
- Lane *i* is valid when `mtc_in[i][MTC_WIDTH-1]==1`. Invalid lanes are ignored regardless of their payload.
- Compaction:
  - Valid lanes are written to consecutive FIFO slots in ascending lane index.
  - `nwr` = number of valid lanes, 0..`MTC_PER_BCID`.
- Pop:
  - `pop = out_valid & out_ready`.
  - `out_ready` while `!out_valid` has no effect.
- Free space this cycle: `free = FIFO_DEPTH - fifo_count + pop`. A pop frees its slot in the same cycle.
- Accept and drop:
  - `acc = min(nwr, free)`. The lowest-indexed `acc` valid lanes are written.
  - The remaining `nwr-acc` valid lanes are dropped.
  - On any drop: `drop_cnt += (nwr-acc)`, saturating; `overflow` is set.
- Occupancy:
  - `fifo_count_next = fifo_count + acc - pop`.
  - Read and write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap modulo `FIFO_DEPTH`.
- Ordering:
  - Words from an earlier cycle always leave before words from a later cycle.
  - Within one cycle, lower lane index leaves first.
- Output:
  - `out_valid = (fifo_count != 0)`, driven from registers.
  - `out_data` = word at the read pointer when `out_valid`, else 0.
  - The full word, including the valid bit, is passed through unmodified.
- Stall: while `out_valid & !out_ready`, `out_data` holds stable.
- Reset (`rst_n` low, or `srst` high at an edge):
  - Pointers, `fifo_count`, `drop_cnt`, `overflow`, `out_valid` and `out_data` all go to 0.
  - FIFO contents are discarded.
  - Inputs present during reset are not captured.
  - `rst_n` clears immediately. `srst` clears at the edge and takes priority over a simultaneous write or pop.

## Timing
- Write latency: a candidate sampled at edge *k* into an empty FIFO gives `out_valid=1` with that word on `out_data` after edge *k*, so it is visible in cycle *k+1*.
- Throughput:
  - One word out per cycle while `out_ready=1`.
  - Up to `MTC_PER_BCID` words in per cycle.
- Back-to-back: with the FIFO empty and 3 valid lanes arriving at edge *k* and `out_ready=1` continuously, words appear in cycles *k+1*, *k+2* and *k+3*.
- A simultaneous pop and write with a full FIFO accepts exactly one extra word (`free=1`).
- All outputs are registered. There is no combinational path from `mtc_in` or `out_ready` to any output.
- First valid sample after `rst_n` deasserts: the edge after deassertion.

## Test plan
- Reset: hold `rst_n=0` with all lanes valid.
  - Required: all outputs 0.
  - Release, then present lanes {A,B,C} for one cycle: `out_valid` the next cycle, and A, B, C emerge in order with `out_ready=1`.
- Sparse lanes: lane 0 invalid, lane 1 = X, lane 2 = Y, `out_ready=1`.
  - Required: `out_data` = X then Y.
  - `fifo_count` goes 2, 1, 0.
  - `drop_cnt` stays 0.
- Overflow: `out_ready=0`, DEPTH=8, 3 valid lanes for 3 cycles.
  - Required: `fifo_count` 3, 6, 8.
  - Third cycle accepts lanes 0 and 1 and drops lane 2.
  - `drop_cnt=1`, `overflow=1`.
  - Draining returns the 8 accepted words in order.
- Full with simultaneous pop: FIFO at 8 with `out_ready=1`, 3 valid lanes.
  - Required: 1 accepted, `fifo_count` stays 8, `drop_cnt` += 2.
- Stall and wrap: random valid patterns and random `out_ready` for 10k cycles against a scoreboard queue.
  - Required: exact order preserved.
  - `out_data` stable under stall.
  - `drop_cnt` equals the model count.
  - Pointers wrap without loss.
- Mid-operation `srst`: FIFO holds 5 words; assert `srst` with `out_ready=1` and valid inputs.
  - Required: the next cycle `fifo_count=0`, `out_valid=0`, `drop_cnt=0`, `overflow=0`.
